// File: rtl/cpu_bus_sized.sv
// CPU-to-system-bus bridge: sized reads with extension, RMW sub-word writes, IRQ sync.
// Optional bus timeout watchdog enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_bus_sized #(
  parameter int ADDR_W  = 24,
  parameter int IRQ_N   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [ADDR_W-3:0] bus_addr,
  input  logic [31:0]       bus_din,
  output logic [31:0]       bus_dout,
  input  logic              bus_ack,
  input  logic [IRQ_N-1:0]  bus_irq,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_din,
  input  logic [31:0]       cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [IRQ_N-1:0]  cpu_irq
);

  typedef enum logic {S_IDLE, S_WB} state_t;

  state_t           state_q, state_d;
  logic [31:0]      wbuf_q, wbuf_d;
  logic [IRQ_N-1:0] irq_s1_q, irq_s2_q;

  logic        is_byte, is_half, rmw;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rdata, merged;

  assign bus_addr = cpu_addr[ADDR_W-1:2];
  assign cpu_irq  = irq_s2_q;

  assign is_byte = (cpu_size == 2'b00);
  assign is_half = (cpu_size == 2'b01);
  assign rmw     = cpu_we & (is_byte | is_half);

  always_comb begin
    rd_byte = bus_din[{cpu_addr[1:0], 3'b000} +: 8];
    rd_half = bus_din[{cpu_addr[1], 4'b0000} +: 16];
    rdata   = bus_din;
    if (is_byte)
      rdata = {{24{cpu_sext & rd_byte[7]}}, rd_byte};
    else if (is_half)
      rdata = {{16{cpu_sext & rd_half[15]}}, rd_half};
  end

  // Lane replacement over the word just read back
  always_comb begin
    merged = bus_din;
    if (is_byte)
      merged[{cpu_addr[1:0], 3'b000} +: 8] = cpu_dout[7:0];
    else
      merged[{cpu_addr[1], 4'b0000} +: 16] = cpu_dout[15:0];
  end

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    wbuf_d   = wbuf_q;
    bus_stb  = 1'b0;
    bus_we   = 1'b0;
    bus_dout = cpu_dout;
    cpu_ack  = 1'b0;
    cpu_err  = 1'b0;
    cpu_din  = rdata;
`ifdef CPU_BUS_TIMEOUT_EN
    cnt_d    = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cpu_stb) begin
          bus_stb = 1'b1;
          if (rmw) begin
            if (bus_ack) begin
              wbuf_d  = merged;
              state_d = S_WB;
            end
          end else begin
            bus_we  = cpu_we;
            cpu_ack = bus_ack;
          end
        end
      end
      S_WB: begin
        bus_stb  = 1'b1;
        bus_we   = 1'b1;
        bus_dout = wbuf_q;
        cpu_ack  = bus_ack;
        if (bus_ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CPU_BUS_TIMEOUT_EN
    // A same-cycle bus_ack beats the watchdog
    if (bus_stb && !bus_ack) begin
      if (cnt_q == TMAX) begin
        bus_stb = 1'b0;
        cpu_ack = 1'b1;
        cpu_err = 1'b1;
        cpu_din = '0;
        state_d = S_IDLE;
        wbuf_d  = wbuf_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
    if (rst) begin
      bus_stb = 1'b0;
      cpu_ack = 1'b0;
      cpu_err = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      irq_s1_q <= '0;
      irq_s2_q <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      irq_s1_q <= bus_irq;
      irq_s2_q <= irq_s1_q;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

endmodule

// File: doc/cpu_bus_sized.md
# cpu_bus_sized

Parametrised CPU bus interface between the RISC5 core and the system bus, successor to the fixed byte/word bridge. Supports byte, halfword and word accesses, with zero or sign extension on sub-word reads. Sub-word writes use a two-phase read-modify-write, because the bus carries no byte enables. An optional bus timeout watchdog and a two-flop interrupt synchroniser are included; the block sits directly between the CPU core and the bus arbiter/decoder.

## Interface
- ADDR_W, 24, byte address width; bus address is [ADDR_W-1:2]
- IRQ_N, 16, number of interrupt request lines
- TIMEOUT, 255, stall cycles tolerated before an error completion (only with CPU_BUS_TIMEOUT_EN); counter width is clog2(TIMEOUT+1)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- bus_stb  out  1  bus request
- bus_we  out  1  bus write (1) / read (0)
- bus_addr  out  ADDR_W-2  word address = cpu_addr[ADDR_W-1:2]
- bus_din  in  32  bus read data
- bus_dout  out  32  bus write data
- bus_ack  in  1  bus completion
- bus_irq  in  IRQ_N  asynchronous interrupt requests
- cpu_stb  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  CPU write
- cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- cpu_sext  in  1  sign-extend sub-word read data
- cpu_addr  in  ADDR_W  byte address; stable until cpu_ack
- cpu_din  out  32  read data to CPU
- cpu_dout  in  32  write data from CPU; stable until cpu_ack
- cpu_ack  out  1  transfer complete
- cpu_err  out  1  completion is a timeout error; valid with cpu_ack
- cpu_irq  out  IRQ_N  synchronised interrupt requests

## Operation
- States: S_IDLE (pass-through/read phase), S_WB (write-back phase of RMW).
- S_IDLE, cpu_stb=0: bus_stb=0, cpu_ack=0.
- Read (any size) or word write: bus_stb=1, bus_we=cpu_we, bus_dout=cpu_dout, cpu_ack=bus_ack combinationally; stay in S_IDLE.
- Lane select: byte uses addr[1:0]; halfword uses addr[1] (addr[0] ignored, access aligned down); word ignores addr[1:0].
- Sub-word read: lane right-justified into cpu_din; upper bits are 0, or copies of the lane MSB when cpu_sext=1.
- Sub-word write, phase 1 in S_IDLE: bus_stb=1, bus_we=0, cpu_ack=0. On bus_ack, latch into wbuf the value bus_din with the selected lane replaced by cpu_dout[7:0] or [15:0]; go to S_WB.
- Phase 2 in S_WB: bus_stb=1, bus_we=1, bus_dout=wbuf, cpu_ack=bus_ack. Go to S_IDLE on bus_ack. The write completes even if cpu_stb falls.
- cpu_irq: two-stage register of bus_irq, reset to 0.

## Timing
- While rst=1 and after release until the next request: bus_stb=0, cpu_ack=0, cpu_err=0, cpu_irq=0, state=S_IDLE, timeout counter=0. wbuf is not reset.
- Reset mid-RMW: state returns to S_IDLE, the write phase is never issued and memory is unchanged.
- Read and word write: cpu_ack appears in the same cycle as bus_ack; minimum 1 cycle.
- Sub-word write: minimum 2 cycles (read ack cycle, then write ack cycle); cpu_ack is asserted only in the write ack cycle.
- IRQ latency: 2 clk edges from bus_irq change to cpu_irq.
- cpu_err=0 whenever cpu_ack is due to bus_ack.

## Configuration
- CPU_BUS_TIMEOUT_EN defined:
  - The counter increments every cycle with bus_stb=1 and bus_ack=0, and clears on bus_ack, on idle, and at the phase change.
  - In the cycle where counter==TIMEOUT and bus_ack=0, the block drives cpu_ack=1, cpu_err=1, cpu_din=0 and bus_stb=0, then returns to S_IDLE with the counter cleared.
  - A timeout in S_WB abandons the write.
  - bus_ack in that same cycle wins: normal completion, cpu_err=0.
- Not defined: no counter, cpu_err tied 0, the block waits for bus_ack indefinitely.

## Test plan
- Byte read, addr=0x000003, bus_din=0x80FF1234, sext=0 -> cpu_din=0x00000080; with sext=1 -> 0xFFFFFF80; cpu_ack in the bus_ack cycle.
- Halfword read, addr=0x000003, bus_din=0x80FF1234, sext=1 -> bus_addr=0x000000, cpu_din=0xFFFF80FF.
- Byte write 0xAB to addr=0x000011, bus_din=0x11223344 -> read phase, then write phase with bus_dout=0x1122AB44; exactly one cpu_ack.
- Halfword write 0xBEEF to addr 0x2, bus_ack delayed 3 cycles per phase -> bus_dout=0xBEEF3344, cpu_ack 8 cycles after request.
- With CPU_BUS_TIMEOUT_EN and TIMEOUT=4, bus_ack never given -> cpu_ack=cpu_err=1 in cycle 5, bus_stb=0. Repeat with bus_ack in cycle 5 -> cpu_err=0.
- rst pulsed during S_WB -> no write cycle, outputs 0. bus_irq[3] rising -> cpu_irq[3] high after 2 edges.
